// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the host-side SPI master.
//   state_t        : transaction FSM states
//   MODE_*         : slave mode encodings carried on the mode output
//   SIZE_*         : key-size encodings carried on size_in / size
//   key_len()      : key-size code -> number of key bits shipped
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEAD   = 3'd1,
        MSG    = 3'd2,
        GAP    = 3'd3,
        KEY    = 3'd4,
        READ   = 3'd5,
        FINISH = 3'd6
    } state_t;

    localparam logic MODE_ENCR = 1'b0;
    localparam logic MODE_DECR = 1'b1;

    localparam logic [1:0] SIZE_128 = 2'b00;
    localparam logic [1:0] SIZE_192 = 2'b01;
    localparam logic [1:0] SIZE_256 = 2'b10;
    localparam logic [1:0] SIZE_BAD = 2'b11;

    function automatic logic [8:0] key_len(input logic [1:0] sz);
        case (sz)
            SIZE_128: key_len = 9'd128;
            SIZE_192: key_len = 9'd192;
            default:  key_len = 9'd256;
        endcase
    endfunction

endpackage

// File: rtl/spi_shift_tx.sv
// spi_shift_tx: loadable LSB-first shift register with a shift counter.
//   clk      in   system clock
//   reset    in   async active-low reset
//   load     in   capture data_in, clear count
//   data_in  in   W-bit parallel word
//   shift    in   move one bit toward bit 0, count += 1
//   bit_out  out  current LSB (next bit to ship)
//   count    out  number of shifts since the last load
module spi_shift_tx #(
    parameter int W     = 128,
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [W-1:0]     data_in,
    input  logic             shift,
    output logic             bit_out,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0] sh_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_q  <= '0;
            count <= '0;
        end else if (load) begin
            sh_q  <= data_in;
            count <= '0;
        end else if (shift) begin
            sh_q  <= {1'b0, sh_q[W-1:1]};
            count <= count + CNT_W'(1);
        end
    end

    assign bit_out = sh_q[0];

endmodule

// File: rtl/spi_master.sv
// spi_master: host-side SPI master feeding the AES SPI slave.
// A load frame ships a dummy bit, the 128-bit message, an idle bit and the
// 128/192/256-bit key, all LSB first, while CSS is low. A read-back frame
// holds CSS low for 129 cycles and gathers 128 SOMI bits into result.
//   clk      in   system clock
//   reset    in   async active-low reset
//   start    in   one-cycle request, honoured only in IDLE
//   op       in   0 load, 1 read-back
//   size_in  in   key size code (11 illegal for load)
//   msg_in   in   plaintext, latched on accepted load
//   key_in   in   key, LSB aligned, latched on accepted load
//   SOMI     in   serial data from slave
//   SIMO     out  serial data to slave
//   CSS      out  chip select, active low
//   mode     out  slave mode, changes only on accepted start
//   size     out  latched key size code
//   busy     out  transaction in progress
//   done     out  end-of-transaction pulse
//   err      out  rejected-start pulse
//   result   out  read-back data
module spi_master
    import spi_pkg::*;
#(
    parameter int MSG_W = 128,
    parameter int KEY_W = 256,
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [1:0]       size_in,
    input  logic [MSG_W-1:0] msg_in,
    input  logic [KEY_W-1:0] key_in,
    input  logic             SOMI,
    output logic             SIMO,
    output logic             CSS,
    output logic             mode,
    output logic [1:0]       size,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [MSG_W-1:0] result
);

    localparam int MSG_AW = $clog2(MSG_W);

    state_t             state_q, state_d;
    logic               css_d, simo_d, mode_d, busy_d, done_d, err_d;
    logic [1:0]         size_d;
    logic [MSG_W-1:0]   result_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [MSG_AW-1:0]  rd_idx;

    logic               msg_load, msg_shift, msg_bit;
    logic               key_load, key_shift, key_bit;
    logic [CNT_W-1:0]   msg_cnt, key_cnt;

    spi_shift_tx #(.W(MSG_W), .CNT_W(CNT_W)) u_msg_tx (
        .clk     (clk),
        .reset   (reset),
        .load    (msg_load),
        .data_in (msg_in),
        .shift   (msg_shift),
        .bit_out (msg_bit),
        .count   (msg_cnt)
    );

    spi_shift_tx #(.W(KEY_W), .CNT_W(CNT_W)) u_key_tx (
        .clk     (clk),
        .reset   (reset),
        .load    (key_load),
        .data_in (key_in),
        .shift   (key_shift),
        .bit_out (key_bit),
        .count   (key_cnt)
    );

    // READ count 0 is the skipped first CSS-low cycle; count c>0 samples bit c-1.
    assign rd_idx = cnt_q[MSG_AW-1:0] - MSG_AW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            CSS     <= 1'b1;
            SIMO    <= 1'b0;
            mode    <= MODE_ENCR;
            size    <= SIZE_128;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            result  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            CSS     <= css_d;
            SIMO    <= simo_d;
            mode    <= mode_d;
            size    <= size_d;
            busy    <= busy_d;
            done    <= done_d;
            err     <= err_d;
            result  <= result_d;
            cnt_q   <= cnt_d;
        end
    end

    // Every output is registered, so each state computes what the wire must
    // carry during the *next* cycle. That is why LEAD already drives msg bit 0
    // and the last KEY cycle raises CSS: the outputs lag the state by one.
    always_comb begin
        state_d   = state_q;
        css_d     = CSS;
        simo_d    = 1'b0;
        mode_d    = mode;
        size_d    = size;
        busy_d    = busy;
        done_d    = 1'b0;
        err_d     = 1'b0;
        result_d  = result;
        cnt_d     = cnt_q;
        msg_load  = 1'b0;
        msg_shift = 1'b0;
        key_load  = 1'b0;
        key_shift = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (op == MODE_DECR) begin
                        css_d   = 1'b0;
                        mode_d  = MODE_DECR;
                        busy_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = READ;
                    end else if (size_in == SIZE_BAD) begin
                        err_d = 1'b1;
                    end else begin
                        msg_load = 1'b1;
                        key_load = 1'b1;
                        size_d   = size_in;
                        mode_d   = MODE_ENCR;
                        css_d    = 1'b0;
                        busy_d   = 1'b1;
                        state_d  = LEAD;
                    end
                end
            end

            LEAD: begin
                simo_d    = msg_bit;
                msg_shift = 1'b1;
                state_d   = MSG;
            end

            MSG: begin
                if (msg_cnt == CNT_W'(MSG_W)) begin
                    state_d = GAP;
                end else begin
                    simo_d    = msg_bit;
                    msg_shift = 1'b1;
                end
            end

            GAP: begin
                simo_d    = key_bit;
                key_shift = 1'b1;
                state_d   = KEY;
            end

            KEY: begin
                if (key_cnt == CNT_W'(key_len(size))) begin
                    css_d   = 1'b1;
                    state_d = FINISH;
                end else begin
                    simo_d    = key_bit;
                    key_shift = 1'b1;
                end
            end

            READ: begin
                if (cnt_q != '0) begin
                    result_d[rd_idx] = SOMI;
                end
                if (cnt_q == CNT_W'(MSG_W)) begin
                    css_d   = 1'b1;
                    state_d = FINISH;
                end
                cnt_d = cnt_q + CNT_W'(1);
            end

            FINISH: begin
                css_d   = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
